// File: rtl/fifo_32_frame_tx.sv
// Pops 32-bit words from the upstream FIFO and sends them as SYNC, LEN, LEN*4 payload bytes (LSB first), CHK frames.
// Latency: a frame starts once MAX_WORDS words are buffered or TIMEOUT idle cycles pass; then one byte per accepted transfer.
// Backpressure: TX_DATA holds while TX_VALID && !TX_READY; pops are issued only in FILL and only while the FIFO is not empty.
module fifo_32_frame_tx #(
    parameter int         MAX_WORDS = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fifo_empty_i,
    output logic        fifo_read_o,
    input  logic [31:0] fifo_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SYNC, S_LEN, S_PAYLOAD, S_CHK
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  issued_q, issued_d;
    logic [CW-1:0]  len_q, len_d;
    logic           cap_q, cap_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [IW-1:0]  word_q, word_d;
    logic [1:0]     byte_q, byte_d;
    logic [7:0]     chk_q, chk_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [31:0]    wbuf_q [2**IW];
    logic           xfer;
    logic [7:0]     pay_byte;

    assign tx_valid_o  = (state_q == S_SYNC) || (state_q == S_LEN) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign xfer        = tx_valid_o && tx_ready_i;
    assign busy_o      = (state_q != S_IDLE);
    assign frame_cnt_o = frame_cnt_q;
    assign pay_byte    = wbuf_q[word_q][8*byte_q +: 8];

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        len_d       = len_q;
        idle_d      = idle_q;
        word_d      = word_q;
        byte_d      = byte_q;
        chk_d       = chk_q;
        frame_cnt_d = frame_cnt_q;
        fifo_read_o = 1'b0;
        tx_data_o   = 8'h00;
        case (state_q)
            S_IDLE: begin
                issued_d = '0;
                idle_d   = '0;
                if (!fifo_empty_i) state_d = S_FILL;
            end
            S_FILL: begin
                fifo_read_o = !fifo_empty_i && (issued_q < CW'(MAX_WORDS));
                if (fifo_read_o) begin
                    issued_d = issued_q + CW'(1);
                    idle_d   = '0;
                end else if (fifo_empty_i && issued_q != '0 && idle_q != TW'(TIMEOUT)) begin
                    idle_d = idle_q + TW'(1);
                end
                // Leave only after the last popped word has been written into the buffer.
                if (!cap_q && !fifo_read_o && issued_q != '0 &&
                    (issued_q == CW'(MAX_WORDS) || idle_q == TW'(TIMEOUT))) begin
                    state_d = S_SYNC;
                    len_d   = issued_q;
                    word_d  = '0;
                    byte_d  = '0;
                end
            end
            S_SYNC: begin
                tx_data_o = SYNC_BYTE;
                if (xfer) state_d = S_LEN;
            end
            S_LEN: begin
                tx_data_o = 8'(len_q);
                if (xfer) begin
                    chk_d   = 8'(len_q);
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                tx_data_o = pay_byte;
                if (xfer) begin
                    chk_d  = chk_q ^ pay_byte;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (CW'(word_q) == len_q - CW'(1)) state_d = S_CHK;
                        else                               word_d  = word_q + IW'(1);
                    end
                end
            end
            S_CHK: begin
                tx_data_o = chk_q;
                if (xfer) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cap_d = fifo_read_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            issued_q    <= '0;
            len_q       <= '0;
            cap_q       <= 1'b0;
            idle_q      <= '0;
            word_q      <= '0;
            byte_q      <= '0;
            chk_q       <= 8'h00;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            len_q       <= len_d;
            cap_q       <= cap_d;
            idle_q      <= idle_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            chk_q       <= chk_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The word popped last cycle lands at the slot just counted by issued_q.
    always_ff @(posedge clk_i) begin
        if (cap_q) wbuf_q[IW'(issued_q - CW'(1))] <= fifo_data_i;
    end

endmodule

// File: tb/tb_fifo_32_frame_tx.sv
// Directed bench for fifo_32_frame_tx with MAX_WORDS=4, TIMEOUT=10; an array-backed FIFO model feeds it.
module tb_fifo_32_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;
    logic [31:0] fifo_data = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fifo_32_frame_tx #(.MAX_WORDS(4), .SYNC_BYTE(8'hA5), .TIMEOUT(10)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(fifo_empty), .fifo_read_o(fifo_read),
        .fifo_data_i(fifo_data), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .busy_o(busy), .frame_cnt_o(frame_cnt)
    );

    logic [31:0] src [64];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always @(posedge clk) begin : fifo_model
        logic rd;
        rd = fifo_read;
        #1;
        if (rd) begin
            fifo_data = src[rd_ptr];
            rd_ptr++;
        end
        fifo_empty = (rd_ptr == wr_ptr);
    end

    logic rdy_rand  = 1'b0;
    logic rdy_level = 1'b1;
    always @(posedge clk) begin
        #1;
        tx_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : rdy_level;
    end

    logic [7:0] rxq [$];
    int   rd_cnt = 0, rd_bad = 0, stab_err = 0, cyc = 0, last_rd_cyc = 0, sync_cyc = 0;
    logic prev_stall = 1'b0, prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h0;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) rxq.push_back(tx_data);
        if (prev_stall && tx_valid && tx_data !== prev_data) stab_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (fifo_read) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (fifo_empty) rd_bad++;
        end
        if (tx_valid && !prev_valid) sync_cyc = cyc;
        prev_valid = tx_valid;
        cyc++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        src[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check_eq({tag, " done"}, 32'(busy), 32'h0);
    endtask

    task automatic expect_frame(input string tag, input int base, input int first, input int len);
        logic [7:0] exp_b [$];
        logic [7:0] c;
        logic [31:0] got;
        c = 8'(len);
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'(len));
        for (int w = 0; w < len; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] x;
                x = src[first + w][8*b +: 8];
                exp_b.push_back(x);
                c ^= x;
            end
        end
        exp_b.push_back(c);
        check_eq({tag, " nbytes"}, 32'(rxq.size() - base), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++) begin
            got = (base + i < rxq.size()) ? 32'(rxq[base + i]) : 32'hFFFF_FFFF;
            check_eq($sformatf("%s byte%0d", tag, i), got, 32'(exp_b[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base, r0, s0, n;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst tx_valid",  32'(tx_valid),  32'h0);
        check_eq("rst busy",      32'(busy),      32'h0);
        check_eq("rst fifo_read", 32'(fifo_read), 32'h0);
        check_eq("rst tx_data",   32'(tx_data),   32'h0);
        check_eq("rst frame_cnt", 32'(frame_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Four words, MAX_WORDS reached, ready held high.
        base = rxq.size(); r0 = rd_cnt;
        push(32'h04030201); push(32'h08070605); push(32'h0C0B0A09); push(32'h100F0E0D);
        wait_frame("t1");
        expect_frame("t1", base, 0, 4);
        check_eq("t1 chk", (base + 18 < rxq.size()) ? 32'(rxq[base + 18]) : 32'hFFFF_FFFF, 32'h14);
        check_eq("t1 reads", 32'(rd_cnt - r0), 32'd4);
        check_eq("t1 frame_cnt", 32'(frame_cnt), 32'd1);

        // One word, closed by the idle timeout.
        base = rxq.size();
        push(32'hDEADBEEF);
        wait_frame("t2");
        expect_frame("t2", base, 4, 1);
        check_eq("t2 chk", (base + 6 < rxq.size()) ? 32'(rxq[base + 6]) : 32'hFFFF_FFFF, 32'h23);
        check_eq("t2 pop to sync cycles", 32'(sync_cyc - last_rd_cyc), 32'd12);
        check_eq("t2 frame_cnt", 32'(frame_cnt), 32'd2);

        // Same four words with a ~30% ready duty cycle.
        base = rxq.size(); s0 = stab_err;
        rdy_rand = 1'b1;
        push(32'h04030201); push(32'h08070605); push(32'h0C0B0A09); push(32'h100F0E0D);
        wait_frame("t3");
        rdy_rand = 1'b0;
        expect_frame("t3", base, 5, 4);
        check_eq("t3 stall stability", 32'(stab_err - s0), 32'd0);
        check_eq("t3 frame_cnt", 32'(frame_cnt), 32'd3);

        // Nine words -> frames of 4, 4, 1.
        base = rxq.size(); r0 = rd_cnt;
        for (int i = 0; i < 9; i++) push(32'hA0000000 + 32'(i) * 32'h01010101);
        wait_frame("t4a");
        expect_frame("t4a", base, 9, 4);
        base = rxq.size();
        wait_frame("t4b");
        expect_frame("t4b", base, 13, 4);
        base = rxq.size();
        wait_frame("t4c");
        expect_frame("t4c", base, 17, 1);
        check_eq("t4 reads", 32'(rd_cnt - r0), 32'd9);
        check_eq("t4 frame_cnt", 32'(frame_cnt), 32'd6);

        // Reset during payload byte 3 of a 4-word frame, 2 words left queued.
        base = rxq.size();
        for (int i = 0; i < 6; i++) push(32'hC0DE0000 + 32'(i));
        n = 0;
        while (rxq.size() < base + 5 && n < 500) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        #1;
        check_eq("t5 byte before reset", 32'(tx_data), 32'(src[18][31:24]));
        rst_n = 1'b0;
        #1;
        check_eq("t5 rst tx_valid",  32'(tx_valid),  32'h0);
        check_eq("t5 rst frame_cnt", 32'(frame_cnt), 32'h0);
        check_eq("t5 rst busy",      32'(busy),      32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        base = rxq.size();
        wait_frame("t5");
        expect_frame("t5", base, 22, 2);
        check_eq("t5 frame_cnt", 32'(frame_cnt), 32'd1);

        // Frame counter wrap.
        @(posedge clk);
        #2;
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #2;
        release dut.frame_cnt_q;
        @(negedge clk);
        check_eq("t6 preload", 32'(frame_cnt), 32'hFFFF);
        base = rxq.size();
        push(32'h55AA55AA);
        wait_frame("t6");
        expect_frame("t6", base, 24, 1);
        check_eq("t6 wrap", 32'(frame_cnt), 32'h0);

        check_eq("reads while empty", 32'(rd_bad), 32'd0);
        check_eq("all words consumed", 32'(rd_ptr), 32'(wr_ptr));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
